// File: rtl/gf2_pkg.sv
// gf2_pkg - shared definitions for the GF(2^2) lane transformer.
//   Elements are 2-bit vectors in normal basis [Omega^2, Omega]:
//   bit 1 is the Omega^2 coefficient, bit 0 the Omega coefficient.
//   Contents: lane width, transform mode enum, accumulate FSM state enum,
//   and the per-lane transform function.
package gf2_pkg;

   localparam int GF2_W = 2;

   typedef enum logic [1:0] {
      GF2_PASS  = 2'd0,
      GF2_SCLW  = 2'd1,
      GF2_SCLW2 = 2'd2,
      GF2_SQ    = 2'd3
   } gf2_mode_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_ACC  = 1'b1
   } gf2_acc_st_e;

   // In the normal basis, squaring (which equals inversion in GF(4)) is a
   // coefficient swap, and scaling by Omega or Omega^2 is a 2-input XOR network.
   function automatic logic [GF2_W-1:0] gf2_xform(input logic [GF2_W-1:0] a,
                                                  input gf2_mode_e       mode);
      logic [GF2_W-1:0] r;
      case (mode)
         GF2_PASS:  r = a;
         GF2_SCLW:  r = {a[1] ^ a[0], a[1]};
         GF2_SCLW2: r = {a[0], a[1] ^ a[0]};
         GF2_SQ:    r = {a[0], a[1]};
         default:   r = a;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/gf2_lane_xform.sv
// gf2_lane_xform - combinational LANES-wide GF(2^2) transform.
//   in_data  : LANES packed 2-bit elements, lane k at [2k+1:2k]
//   in_mode  : transform applied to every lane (gf2_mode_e encoding)
//   out_data : transformed lanes, same packing
module gf2_lane_xform
   import gf2_pkg::*;
#(
   parameter int LANES = 8
) (
   input  logic [GF2_W*LANES-1:0] in_data,
   input  logic [1:0]             in_mode,
   output logic [GF2_W*LANES-1:0] out_data
);

   for (genvar k = 0; k < LANES; k++) begin : g_lane
      assign out_data[GF2_W*k +: GF2_W] =
         gf2_xform(in_data[GF2_W*k +: GF2_W], gf2_mode_e'(in_mode));
   end

endmodule

// File: rtl/gf2_scl_pipe.sv
// gf2_scl_pipe - pipelined GF(2^2) lane transformer with elastic
// valid/ready handshake on both sides.
//   Parameters: LANES (1..64) elements per beat, STAGES (1..4) register depth.
//   Ports:
//     clk, rst_n              clock, asynchronous active-low reset
//     in_valid/in_ready       input handshake
//     in_data, in_mode        lanes and per-beat transform selection
//     in_last                 burst terminator (carried to out_last)
//     in_acc                  start/continue accumulation (GF2_SCL_ACC_EN only)
//     out_valid/out_ready     output handshake
//     out_data, out_last      registered results from the final stage
//   Build option: define GF2_SCL_ACC_EN to add the XOR-accumulate FSM and
//   the in_acc port. Without it every accepted beat enters the pipe.
module gf2_scl_pipe
   import gf2_pkg::*;
#(
   parameter int LANES  = 8,
   parameter int STAGES = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [GF2_W*LANES-1:0] in_data,
   input  logic [1:0]             in_mode,
   input  logic                   in_last,
`ifdef GF2_SCL_ACC_EN
   input  logic                   in_acc,
`endif
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [GF2_W*LANES-1:0] out_data,
   output logic                   out_last
);

   localparam int DW = GF2_W * LANES;

   logic [DW-1:0]     xf_s;
   logic [DW-1:0]     push_d_s;
   logic              push_s;
   logic [STAGES-1:0] vld_s;
   logic [STAGES-1:0] advance_s;

   gf2_lane_xform #(.LANES(LANES)) u_xform (
      .in_data  (in_data),
      .in_mode  (in_mode),
      .out_data (xf_s)
   );

`ifdef GF2_SCL_ACC_EN
   gf2_acc_st_e   st_r;
   logic [DW-1:0] acc_r;
   logic          absorb_s;
   logic          accept_s;

   // Classify the current beat: absorbed into acc, or pushed (plain or burst result).
   always_comb begin
      absorb_s = 1'b0;
      push_d_s = xf_s;
      case (st_r)
         ST_IDLE: begin
            absorb_s = in_acc & ~in_last;
            push_d_s = xf_s;
         end
         ST_ACC: begin
            absorb_s = ~in_last;
            push_d_s = acc_r ^ xf_s;
         end
         default: begin
            absorb_s = 1'b0;
            push_d_s = xf_s;
         end
      endcase
   end

   // Absorbed beats never touch the pipe, so they are accepted even when it is full.
   assign in_ready = absorb_s | advance_s[0];
   assign accept_s = in_valid & in_ready;
   assign push_s   = accept_s & ~absorb_s;

   // Accumulate FSM: IDLE opens a burst on in_acc, ACC folds beats until in_last.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_r  <= ST_IDLE;
         acc_r <= {DW{1'b0}};
      end else if (accept_s) begin
         case (st_r)
            ST_IDLE: begin
               if (in_acc && !in_last) begin
                  acc_r <= xf_s;
                  st_r  <= ST_ACC;
               end
            end
            ST_ACC: begin
               if (in_last) begin
                  acc_r <= {DW{1'b0}};
                  st_r  <= ST_IDLE;
               end else begin
                  acc_r <= acc_r ^ xf_s;
               end
            end
            default: begin
               acc_r <= {DW{1'b0}};
               st_r  <= ST_IDLE;
            end
         endcase
      end
   end
`else
   assign push_d_s = xf_s;
   assign in_ready = advance_s[0];
   assign push_s   = in_valid & advance_s[0];
`endif

   // Stage i may load when any stage from i onward is empty or the output drains.
   // Written without a ready chain so there is no combinational loop through stages.
   for (genvar i = 0; i < STAGES; i++) begin : g_stage
      localparam logic [STAGES-1:0] LO_MASK = (STAGES'(1) << i) - STAGES'(1);

      logic          v_r;
      logic [DW-1:0] d_r;
      logic          l_r;
      logic          vin_s;
      logic [DW-1:0] din_s;
      logic          lin_s;

      if (i == 0) begin : g_head
         assign vin_s = push_s;
         assign din_s = push_d_s;
         assign lin_s = in_last;
      end else begin : g_body
         assign vin_s = g_stage[i-1].v_r;
         assign din_s = g_stage[i-1].d_r;
         assign lin_s = g_stage[i-1].l_r;
      end

      assign vld_s[i]     = v_r;
      assign advance_s[i] = out_ready | ~(&(vld_s | LO_MASK));

      // Stage register; payload is only captured with a valid beat so that
      // bubbles do not disturb the held data.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            v_r <= 1'b0;
            d_r <= {DW{1'b0}};
            l_r <= 1'b0;
         end else if (advance_s[i]) begin
            v_r <= vin_s;
            if (vin_s) begin
               d_r <= din_s;
               l_r <= lin_s;
            end
         end
      end
   end

   assign out_valid = g_stage[STAGES-1].v_r;
   assign out_data  = g_stage[STAGES-1].d_r;
   assign out_last  = g_stage[STAGES-1].l_r;

endmodule

// File: tb/tb_gf2_scl_pipe.sv
// tb_gf2_scl_pipe - self-checking bench for gf2_scl_pipe (LANES=2, STAGES=2).
// The reference model works in GF(4) polynomial arithmetic (x^2+x+1) after a
// basis change from the normal basis, and a scoreboard queue holds every
// expected output beat. Accumulate scenarios build only with GF2_SCL_ACC_EN.
module tb_gf2_scl_pipe;

   localparam int L      = 2;
   localparam int STAGES = 2;
   localparam int DW     = 2 * L;

   typedef struct packed {
      logic [DW-1:0] d;
      logic          l;
      logic [31:0]   c;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_data;
   logic [1:0]    in_mode;
   logic          in_last;
`ifdef GF2_SCL_ACC_EN
   logic          in_acc;
`endif
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_data;
   logic          out_last;

   int            n_chk = 0;
   int            n_err = 0;
   int            cyc   = 0;
   logic          lat_chk = 1'b0;
   logic          stall_prev = 1'b0;
   logic [DW-1:0] held_d;
   logic          held_l;
   exp_t          q[$];
   exp_t          out_log[$];
   logic          m_acc_on = 1'b0;
   logic [DW-1:0] m_acc = '0;

   gf2_scl_pipe #(.LANES(L), .STAGES(STAGES)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_mode   (in_mode),
      .in_last   (in_last),
`ifdef GF2_SCL_ACC_EN
      .in_acc    (in_acc),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // GF(4) multiply, polynomial basis, reduction by x^2 = x + 1.
   function automatic int gmul(input int x, input int y);
      int r = 0;
      for (int i = 0; i < 2; i++)
         if (((y >> i) & 1) != 0) r = r ^ (x << i);
      if ((r & 4) != 0) r = r ^ 7;
      return r & 3;
   endfunction

   // Reference transform: normal {a1,a0} -> polynomial, operate, convert back.
   function automatic logic [DW-1:0] m_xf(input logic [DW-1:0] d, input int mode);
      logic [DW-1:0] o;
      int a1, a0, p, r, c, w;
      for (int k = 0; k < L; k++) begin
         a1 = int'(d[2*k+1]);
         a0 = int'(d[2*k]);
         p  = ((a1 ^ a0) << 1) | a1;       // Omega^2 = Omega + 1
         case (mode)
            0:       r = p;
            1:       r = gmul(p, 2);
            2:       r = gmul(p, 3);
            default: r = gmul(p, p);
         endcase
         c = r & 1;
         w = (r >> 1) & 1;
         o[2*k+1] = c[0];
         o[2*k]   = w[0] ^ c[0];
      end
      return o;
   endfunction

   // Compare process: checks outputs against the scoreboard and feeds the model.
   always @(negedge clk) begin
      logic [DW-1:0] xv;
      if (!rst_n) begin
         stall_prev = 1'b0;
      end else begin
         if (stall_prev) begin
            chk("stall_valid", {31'd0, out_valid}, 32'd1);
            chk("stall_data", {{(32-DW){1'b0}}, out_data}, {{(32-DW){1'b0}}, held_d});
            chk("stall_last", {31'd0, out_last}, {31'd0, held_l});
         end
         if (out_valid) begin
            if (q.size() == 0) begin
               n_chk++;
               n_err++;
               $display("FAIL unexpected_out: got %0h, expected no beat (cycle %0d)", out_data, cyc);
            end else begin
               chk("out_data", {{(32-DW){1'b0}}, out_data}, {{(32-DW){1'b0}}, q[0].d});
               chk("out_last", {31'd0, out_last}, {31'd0, q[0].l});
               if (lat_chk && !stall_prev)
                  chk("latency", cyc - int'(q[0].c), STAGES);
            end
            if (out_ready) begin
               out_log.push_back('{d: out_data, l: out_last, c: cyc});
               if (q.size() > 0) void'(q.pop_front());
            end
         end
         stall_prev = out_valid && !out_ready;
         held_d     = out_data;
         held_l     = out_last;
         if (in_valid && in_ready) begin
            xv = m_xf(in_data, int'(in_mode));
`ifdef GF2_SCL_ACC_EN
            if (m_acc_on) begin
               if (!in_last) begin
                  m_acc = m_acc ^ xv;
               end else begin
                  q.push_back('{d: m_acc ^ xv, l: 1'b1, c: cyc});
                  m_acc    = '0;
                  m_acc_on = 1'b0;
               end
            end else if (in_acc && !in_last) begin
               m_acc    = xv;
               m_acc_on = 1'b1;
            end else begin
               q.push_back('{d: xv, l: in_last, c: cyc});
            end
`else
            q.push_back('{d: xv, l: in_last, c: cyc});
`endif
         end
      end
   end

   task automatic send(input logic [DW-1:0] d, input logic [1:0] m, input logic lst);
      logic ok = 1'b0;
      in_valid = 1'b1;
      in_data  = d;
      in_mode  = m;
      in_last  = lst;
      for (int t = 0; t < 200; t++) begin
         @(negedge clk);
         if (in_ready) begin
            ok = 1'b1;
            break;
         end
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk("send_accepted", {31'd0, ok}, 32'd1);
   endtask

`ifdef GF2_SCL_ACC_EN
   task automatic send_acc(input logic [DW-1:0] d, input logic [1:0] m, input logic lst);
      in_acc = 1'b1;
      send(d, m, lst);
      in_acc = 1'b0;
   endtask
`endif

   task automatic wait_drain();
      for (int t = 0; t < 500; t++) begin
         @(negedge clk);
         if (q.size() == 0 && !out_valid) break;
      end
      chk("drain_empty", q.size(), 32'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin : main
      logic [DW-1:0] exp1 [4];
      logic [DW-1:0] dv;
      int            cnt;
      logic          rdy_last;

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      in_mode   = 2'd0;
      in_last   = 1'b0;
`ifdef GF2_SCL_ACC_EN
      in_acc    = 1'b0;
`endif
      out_ready = 1'b1;

      // Pin the reference model on the hand-computed LANES=2 vector.
      exp1 = '{4'b1001, 4'b1110, 4'b0111, 4'b0110};
      for (int m = 0; m < 4; m++)
         chk("model_pin", {28'd0, m_xf(4'b1001, m)}, {28'd0, exp1[m]});

      repeat (3) @(posedge clk);
      #2;
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_out_data", {28'd0, out_data}, 32'd0);
      chk("rst_out_last", {31'd0, out_last}, 32'd0);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Four modes back-to-back on 1001; outputs on consecutive cycles.
      out_log.delete();
      lat_chk = 1'b1;
      for (int m = 0; m < 4; m++) send(4'b1001, 2'(m), 1'(m == 3));
      wait_drain();
      lat_chk = 1'b0;
      chk("dir_count", out_log.size(), 32'd4);
      for (int i = 0; i < 4 && i < out_log.size(); i++) begin
         chk("dir_data", {28'd0, out_log[i].d}, {28'd0, exp1[i]});
         chk("dir_spacing", out_log[i].c - out_log[0].c, i);
      end

      // Stall: empty pipe takes one beat per stage, then in_ready drops.
      out_ready = 1'b0;
      cnt       = 0;
      rdy_last  = 1'b0;
      dv        = 4'b0001;
      for (int t = 0; t < 10; t++) begin
         in_valid = 1'b1;
         in_data  = dv;
         in_mode  = 2'(t);
         in_last  = 1'b0;
         @(negedge clk);
         rdy_last = in_ready;
         if (in_ready) cnt++;
         @(posedge clk);
         #1;
         if (rdy_last) dv = dv + 4'd3;
      end
      in_valid = 1'b0;
      chk("stall_accepts", cnt, STAGES);
      chk("stall_in_ready", {31'd0, rdy_last}, 32'd0);
      out_ready = 1'b1;
      wait_drain();

      // Random valid/ready traffic against the scoreboard.
      for (int t = 0; t < 400; t++) begin
         in_valid  = 1'($urandom_range(0, 1));
         in_data   = 4'($urandom);
         in_mode   = 2'($urandom);
         in_last   = ($urandom_range(0, 3) == 0);
`ifdef GF2_SCL_ACC_EN
         in_acc    = ($urandom_range(0, 3) == 0);
`endif
         out_ready = ($urandom_range(0, 9) < 7);
         @(posedge clk);
         #1;
      end
      in_valid  = 1'b0;
`ifdef GF2_SCL_ACC_EN
      in_acc    = 1'b0;
`endif
      out_ready = 1'b1;
      send(4'b0101, 2'd0, 1'b1);   // closes any open burst
      wait_drain();

      // Reset with beats in flight (and a partial burst when accumulating).
      out_ready = 1'b0;
      send(4'b1100, 2'd0, 1'b0);
      send(4'b0011, 2'd1, 1'b0);
      chk("pre_reset_valid", {31'd0, out_valid}, 32'd1);
`ifdef GF2_SCL_ACC_EN
      send_acc(4'b1111, 2'd0, 1'b0);
`endif
      #1;
      rst_n = 1'b0;
      q.delete();
      m_acc    = '0;
      m_acc_on = 1'b0;
      #1;
      chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
      chk("mid_rst_data", {28'd0, out_data}, 32'd0);
      chk("mid_rst_ready", {31'd0, in_ready}, 32'd1);
      repeat (2) @(posedge clk);
      #2;
      rst_n     = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_log.delete();
`ifdef GF2_SCL_ACC_EN
      send_acc(4'b0011, 2'd0, 1'b0);
      send(4'b0001, 2'd0, 1'b1);
      wait_drain();
      chk("post_rst_count", out_log.size(), 32'd1);
      if (out_log.size() > 0) chk("post_rst_data", {28'd0, out_log[0].d}, 32'b0010);

      // Three-beat burst: 1001 ^ 0110 ^ xform(0011, mode 1) = 1111 ^ 0001.
      out_log.delete();
      send_acc(4'b1001, 2'd0, 1'b0);
      send(4'b0110, 2'd0, 1'b0);
      send(4'b0011, 2'd1, 1'b1);
      wait_drain();
      chk("burst_count", out_log.size(), 32'd1);
      if (out_log.size() > 0) begin
         chk("burst_data", {28'd0, out_log[0].d}, 32'b1110);
         chk("burst_last", {31'd0, out_log[0].l}, 32'd1);
      end

      // Single-beat burst stays in IDLE: a following plain beat passes through.
      out_log.delete();
      send_acc(4'b1000, 2'd2, 1'b1);
      send(4'b1001, 2'd1, 1'b0);
      wait_drain();
      chk("single_count", out_log.size(), 32'd2);
      if (out_log.size() > 1) begin
         chk("single_data", {28'd0, out_log[0].d}, 32'b0100);
         chk("single_last", {31'd0, out_log[0].l}, 32'd1);
         chk("single_follow", {28'd0, out_log[1].d}, 32'b1110);
      end
`else
      send(4'b0110, 2'd1, 1'b1);
      wait_drain();
      chk("post_rst_count", out_log.size(), 32'd1);
      if (out_log.size() > 0) begin
         chk("post_rst_data", {28'd0, out_log[0].d}, 32'b1011);
         chk("post_rst_last", {31'd0, out_log[0].l}, 32'd1);
      end
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
